// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: circular FIFO of {pc, inst} pairs between fetch and decode.
// Wrap-bit pointers distinguish full from empty; a taken branch discards every entry.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_inst,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    logic [63:0] mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = wptr - rptr;

    // Reset and flush both empty the queue; flush also swallows any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + (AW+1)'(1);
            end
            if (pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset && !flush) begin
            mem[wptr[AW-1:0]] <= {in_pc, in_inst};
        end
    end

    // Head is read straight from storage; zeroed when empty so stale entries never leak.
    always_comb begin
        out_pc   = 32'h0;
        out_inst = 32'h0;
        if (!empty) begin
            out_pc   = mem[rptr[AW-1:0]][63:32];
            out_inst = mem[rptr[AW-1:0]][31:0];
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the FIFO.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [31:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_ready;
    logic [AW:0]   count;

    int passCount  = 0;
    int checkCount = 0;
    bit modelEn    = 1'b0;

    logic [63:0] mq[$];
    bit          mPush;
    bit          mPop;

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                                 input logic rdy, input logic fl, input logic rst);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference FIFO: a plain queue holding everything accepted and not yet consumed.
    always @(posedge clk) begin
        if (reset || flush) begin
            mq.delete();
        end else begin
            mPush = in_valid && (mq.size() < DEPTH);
            mPop  = out_ready && (mq.size() > 0);
            if (mPop) begin
                void'(mq.pop_front());
            end
            if (mPush) begin
                mq.push_back({in_pc, in_inst});
            end
        end
    end

    always @(negedge clk) begin
        if (modelEn) begin
            checkOutput("model out_valid", 32'(out_valid), 32'(mq.size() > 0));
            checkOutput("model in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            checkOutput("model count", 32'(count), 32'(mq.size()));
            checkOutput("model out_pc", out_pc, (mq.size() > 0) ? mq[0][63:32] : 32'h0);
            checkOutput("model out_inst", out_inst, (mq.size() > 0) ? mq[0][31:0] : 32'h0);
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_inst = '0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 1);
        reset   = 1'b0;
        modelEn = 1'b1;

        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset out_pc", out_pc, 32'h0);
        checkOutput("reset out_inst", out_inst, 32'h0);

        // Fill to capacity, then try one more push.
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1, 32'hBFC0_0000 + 32'(4 * k), 32'h1000 + 32'(k), 0, 0, 0);
            checkOutput("fill count", 32'(count), 32'(k + 1));
        end
        checkOutput("fill in_ready", 32'(in_ready), 32'd0);
        applyStimulus(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 0);
        checkOutput("overfill count", 32'(count), 32'd8);

        for (int k = 0; k < 8; k++) begin
            checkOutput("drain out_pc", out_pc, 32'hBFC0_0000 + 32'(4 * k));
            checkOutput("drain out_inst", out_inst, 32'h1000 + 32'(k));
            applyStimulus(0, 0, 0, 1, 0, 0);
        end
        checkOutput("drained out_valid", 32'(out_valid), 32'd0);
        checkOutput("drained out_pc", out_pc, 32'h0);

        // Steady stream at occupancy 3 across pointer wrap.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 32'h1000_0000 + 32'(4 * k), 32'(k), 0, 0, 0);
        end
        for (int j = 0; j < 20; j++) begin
            checkOutput("stream out_pc", out_pc, 32'h1000_0000 + 32'(4 * j));
            applyStimulus(1, 32'h1000_0000 + 32'(4 * (j + 3)), 32'(j + 3), 1, 0, 0);
            checkOutput("stream count", 32'(count), 32'd3);
        end

        // Flush racing a push and a pop at occupancy 5.
        applyStimulus(1, 32'h2000_0000, 32'h1, 0, 0, 0);
        applyStimulus(1, 32'h2000_0004, 32'h2, 0, 0, 0);
        checkOutput("pre-flush count", 32'(count), 32'd5);
        applyStimulus(1, 32'hFFFF_0000, 32'hFFFF_0000, 1, 1, 0);
        checkOutput("flush count", 32'(count), 32'd0);
        checkOutput("flush out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush in_ready", 32'(in_ready), 32'd1);
        applyStimulus(0, 0, 0, 1, 0, 0);
        checkOutput("post-flush out_valid", 32'(out_valid), 32'd0);

        // Push into an empty queue: head appears one edge later.
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_0013; out_ready = 1'b0;
        #1;
        checkOutput("empty-push same-cycle out_valid", 32'(out_valid), 32'd0);
        applyStimulus(1, 32'h8000_0000, 32'h0000_0013, 0, 0, 0);
        checkOutput("empty-push out_valid", 32'(out_valid), 32'd1);
        checkOutput("empty-push out_pc", out_pc, 32'h8000_0000);
        applyStimulus(0, 0, 0, 1, 0, 0);

        // Reset mid-operation at occupancy 6.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 32'h3000_0000 + 32'(4 * k), 32'(k), 0, 0, 0);
        end
        checkOutput("pre-reset count", 32'(count), 32'd6);
        applyStimulus(1, 32'h3333_3333, 32'h0, 1, 0, 1);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset count", 32'(count), 32'd0);
        checkOutput("midreset out_pc", out_pc, 32'h0);
        checkOutput("midreset out_inst", out_inst, 32'h0);
        applyStimulus(1, 32'h1234_5678, 32'hCAFE_F00D, 0, 0, 0);
        checkOutput("post-reset push out_pc", out_pc, 32'h1234_5678);
        checkOutput("post-reset push out_inst", out_inst, 32'hCAFE_F00D);
        checkOutput("post-reset push count", 32'(count), 32'd1);

        // Random traffic checked by the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 4) != 0, $urandom, $urandom,
                          ($urandom % 3) != 0, ($urandom % 60) == 0, ($urandom % 250) == 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0);

        modelEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
